onewire_bit_engine: RTL and testbench
=====================================

// Module: onewire_bit_engine
// PURPOSE
//  Byte/bit timing engine directly downstream of control_logic/transaction_fsm.
//  Accepts one command per handshake (RESET, WRITE byte, READ byte, PRESENCE query)
//  and generates standard-speed 1-Wire waveforms on an open-drain pad.
//  Samples the bus and returns read data and the presence result.
// PARAMETERS
//  CLK_PER_US  50   clocks per microsecond (prescaler terminal count); must be >= 4
//  T_RSTL      480  reset low time, us
//  T_MSP       70   presence sample point after reset release, us
//  T_RSTH      480  total release/recovery time after reset low, us
//  T_LOW1      6    low time, write-1 and read slots, us
//  T_LOW0      60   low time, write-0 slot, us
//  T_SLOT      70   total slot length (low + release), us
//  T_MSR       15   read sample point from slot start, us
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active-high
//  cmd_valid     in   1  command request
//  cmd_ready     out  1  engine idle; command accepted when cmd_valid & cmd_ready
//  cmd           in   2  00 WRITE, 01 READ, 10 RESET, 11 PRESENCE
//  data_in       in   8  byte to write; captured at acceptance
//  done          out  1  one-cycle pulse at command completion
//  data_out      out  8  READ result; updated only on READ completion
//  presence      out  1  1 = slave answered the last RESET
//  busy          out  1  command in progress (= ~cmd_ready)
//  ow_drive_low  out  1  1 = pad pulls bus low; 0 = released (pull-up)
//  ow_in         in   1  bus sense from pad, asynchronous
// BEHAVIOUR
//  Reset: state IDLE, cmd_ready=1, busy=0, done=0, data_out=8'h00, presence=0,
//   ow_drive_low=0 immediately (async); both sync flops preset to 1.
//  ow_in passes a 2-flop synchronizer; all samples use the synchronized value.
//  Prescaler: clock counter cleared at command acceptance and on every state change;
//   emits us_tick every CLK_PER_US clocks. The 9-bit us_cnt counts ticks within a state.
//  States: IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, DONE.
//  IDLE: cmd_ready=1. On accept: latch cmd and data_in into the shift register; bit_cnt=0.
//   RESET -> RST_LOW. WRITE or READ -> SLOT_LOW. PRESENCE -> DONE, with no bus activity.
//  RST_LOW: drive low for T_RSTL us -> RST_REL.
//  RST_REL: released. At us_cnt==T_MSP, presence <= ~sync_in. After T_RSTH us -> DONE.
//  SLOT_LOW: drive low. Low time is T_LOW0 if WRITE with shift[0]=0, else T_LOW1.
//   Then -> SLOT_REL.
//  SLOT_REL: released. READ: at T_MSR us from slot start, shift in sync_in as MSB
//   (right shift, LSB first on the wire). Slot ends at T_SLOT us from start.
//   bit_cnt==7 -> DONE; else bit_cnt++, WRITE shifts right, -> SLOT_LOW.
//  DONE: one cycle. done=1, cmd_ready=0. READ loads data_out=shift.
//   Next cycle -> IDLE.
//  Latency: accept-to-done for RESET = (T_RSTL+T_RSTH)*CLK_PER_US + 1 clocks;
//   for a byte = 8*T_SLOT*CLK_PER_US + 1; for PRESENCE = 1.
//  cmd_valid while busy or in DONE is ignored; cmd and data_in changes are ignored after accept.
//  The engine never drives high. ow_drive_low is registered and glitch-free.
//  Async rst mid-operation: bus released the same instant; the partial byte is discarded.
//  A bus held low externally does not stall the engine; timing is open-loop.
// TESTING (CLK_PER_US=4 in sim)
//  RESET, slave model pulls low 15-240us after release -> ow_drive_low high exactly
//   1920 clks, presence=1, done at 3841 clks.
//  RESET, no slave -> presence=0, same timing; a following PRESENCE cmd -> done
//   after 1 clk, presence still 0.
//  WRITE 0xA5 -> 8 low pulses of 6,60,6,60,60,6,60,6 us; each slot 280 clks;
//   data_out unchanged.
//  READ, slave pulls low during bits 0,1,6,7 -> data_out=8'h3C at done; low pulses all 6us.
//  cmd_valid held high with new cmds during a WRITE -> only the first accepted;
//   cmd_ready=1 only in IDLE.
//  rst asserted mid-WRITE while driving low -> ow_drive_low=0 same cycle;
//   outputs at reset values; next RESET cmd is accepted normally.

Source files
------------

// File: rtl/onewire_bit_engine.sv
// Standard-speed 1-Wire bit/byte timing engine: turns RESET/WRITE/READ/PRESENCE
// commands into open-drain waveforms and samples the bus for read data and presence.
`timescale 1ns/1ps
module onewire_bit_engine #(
   parameter int CLK_PER_US = 50,
   parameter int T_RSTL     = 480,
   parameter int T_MSP      = 70,
   parameter int T_RSTH     = 480,
   parameter int T_LOW1     = 6,
   parameter int T_LOW0     = 60,
   parameter int T_SLOT     = 70,
   parameter int T_MSR      = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] data_in,
   output logic       done,
   output logic [7:0] data_out,
   output logic       presence,
   output logic       busy,
   output logic       ow_drive_low,
   input  logic       ow_in
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   localparam logic [1:0] CMD_WRITE    = 2'b00;
   localparam logic [1:0] CMD_READ     = 2'b01;
   localparam logic [1:0] CMD_RESET    = 2'b10;
   localparam logic [1:0] CMD_PRESENCE = 2'b11;

   localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_US - 1);

   // Terminal us counts are "last microsecond" values, so a phase of N us
   // ends on the tick that closes microsecond N-1.
   localparam logic [8:0] RSTL_END = 9'(T_RSTL - 1);
   localparam logic [8:0] RSTH_END = 9'(T_RSTH - 1);
   localparam logic [8:0] MSP_AT   = 9'(T_MSP);
   localparam logic [8:0] LOW1_END = 9'(T_LOW1 - 1);
   localparam logic [8:0] LOW0_END = 9'(T_LOW0 - 1);
   localparam logic [8:0] REL1_END = 9'(T_SLOT - T_LOW1 - 1);
   localparam logic [8:0] REL0_END = 9'(T_SLOT - T_LOW0 - 1);
   localparam logic [8:0] MSR_AT   = 9'(T_MSR - T_LOW1);

   typedef enum logic [2:0] {
      IDLE,
      RST_LOW,
      RST_REL,
      SLOT_LOW,
      SLOT_REL,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic          sync_p0;
   logic          sync_p1;
   logic [PW-1:0] clk_cnt;
   logic [8:0]    us_cnt;
   logic          us_tick;

   logic [1:0]    cmd_r;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;

   logic          accept;
   logic          long_low;
   logic          rst_low_end;
   logic          rst_rel_end;
   logic          low_end;
   logic          rel_end;
   logic          last_bit;
   logic          sample_pres;
   logic          sample_bit;
   logic          byte_end;

   // Bus sense synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= ow_in;
         sync_p1 <= sync_p0;
      end
   end

   assign accept   = cmd_valid && cmd_ready;
   assign us_tick  = (clk_cnt == PRE_TC);
   assign last_bit = (bit_cnt == 3'd7);

   // Only a write-0 slot uses the long low time; reads always use the short one.
   assign long_low    = (cmd_r == CMD_WRITE) && !shift[0];
   assign rst_low_end = us_tick && (us_cnt == RSTL_END);
   assign rst_rel_end = us_tick && (us_cnt == RSTH_END);
   assign low_end     = us_tick && (us_cnt == (long_low ? LOW0_END : LOW1_END));
   assign rel_end     = us_tick && (us_cnt == (long_low ? REL0_END : REL1_END));
   assign byte_end    = (state == SLOT_REL) && rel_end && last_bit;

   // us_cnt restarts in SLOT_REL, so the read sample point is offset by the low time.
   assign sample_pres = (state == RST_REL) && (us_cnt == MSP_AT) && (clk_cnt == '0);
   assign sample_bit  = (state == SLOT_REL) && (cmd_r == CMD_READ) &&
                        (us_cnt == MSR_AT) && (clk_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (accept) begin
               case (cmd)
                  CMD_RESET:    state_nxt = RST_LOW;
                  CMD_PRESENCE: state_nxt = DONE;
                  default:      state_nxt = SLOT_LOW;
               endcase
            end
         end
         RST_LOW: begin
            if (rst_low_end) state_nxt = RST_REL;
         end
         RST_REL: begin
            if (rst_rel_end) state_nxt = DONE;
         end
         SLOT_LOW: begin
            if (low_end) state_nxt = SLOT_REL;
         end
         SLOT_REL: begin
            if (rel_end) state_nxt = last_bit ? DONE : SLOT_LOW;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Prescaler and per-state microsecond counter; both restart on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt <= '0;
         us_cnt  <= '0;
      end else if ((state == IDLE) || (state_nxt != state)) begin
         clk_cnt <= '0;
         us_cnt  <= '0;
      end else if (us_tick) begin
         clk_cnt <= '0;
         us_cnt  <= us_cnt + 9'd1;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_r        <= CMD_WRITE;
         bit_cnt      <= 3'd0;
         data_out     <= 8'h00;
         presence     <= 1'b0;
         ow_drive_low <= 1'b0;
      end else begin
         if (accept) begin
            cmd_r   <= cmd;
            bit_cnt <= 3'd0;
         end else if ((state == SLOT_REL) && rel_end && !last_bit) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (sample_pres) begin
            presence <= ~sync_p1;
         end
         // Loaded on entry to DONE so the byte is valid while done is high.
         if (byte_end && (cmd_r == CMD_READ)) begin
            data_out <= shift;
         end
         ow_drive_low <= (state_nxt == RST_LOW) || (state_nxt == SLOT_LOW);
      end
   end

   // Shift register: LSB goes out first; read bits enter at the MSB.
   always_ff @(posedge clk) begin
      if (accept) begin
         shift <= data_in;
      end else if (sample_bit) begin
         shift <= {sync_p1, shift[7:1]};
      end else if ((state == SLOT_REL) && rel_end && !last_bit && (cmd_r == CMD_WRITE)) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

endmodule

// File: tb/tb_onewire_bit_engine.sv
// Bench for onewire_bit_engine: table vectors, random commands against a timing
// model, and directed sequences for held cmd_valid and reset during a write.
`timescale 1ns/1ps
module tb_onewire_bit_engine;

   localparam int CPU    = 4;
   localparam int T_RSTL = 480;
   localparam int T_RSTH = 480;
   localparam int T_LOW1 = 6;
   localparam int T_LOW0 = 60;
   localparam int T_SLOT = 70;

   localparam logic [1:0] WR = 2'b00;
   localparam logic [1:0] RD = 2'b01;
   localparam logic [1:0] RS = 2'b10;
   localparam logic [1:0] PR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd = 2'b00;
   logic [7:0] data_in = 8'h00;
   logic       done;
   logic [7:0] data_out;
   logic       presence;
   logic       busy;
   logic       ow_drive_low;
   logic       ow_in;
   logic       slave_low = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   // Slave / bus monitor state
   bit         slave_on = 1'b0;
   logic [7:0] mask_bits = 8'h00;
   int         pulses[$];
   longint     starts[$];
   longint     cyc = 0;
   int         acc_cnt = 0;

   always #5 clk = ~clk;

   assign ow_in = ~(ow_drive_low | slave_low);

   onewire_bit_engine #(.CLK_PER_US(CPU)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd          (cmd),
      .data_in      (data_in),
      .done         (done),
      .data_out     (data_out),
      .presence     (presence),
      .busy         (busy),
      .ow_drive_low (ow_drive_low),
      .ow_in        (ow_in)
   );

   function automatic void check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endfunction

   // Reference timing derived directly from the 1-Wire slot rules.
   function automatic int model_low(input logic [1:0] c, input logic [7:0] d, input int i);
      case (c)
         WR:      return d[i] ? T_LOW1 * CPU : T_LOW0 * CPU;
         RD:      return T_LOW1 * CPU;
         RS:      return T_RSTL * CPU;
         default: return 0;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] c);
      case (c)
         RS:      return (T_RSTL + T_RSTH) * CPU + 1;
         PR:      return 1;
         default: return 8 * T_SLOT * CPU + 1;
      endcase
   endfunction

   // Slave: answers resets with a presence pulse 30..150us after release, and
   // holds the bus low for 30us in read slots whose mask bit is set.
   initial begin
      int hold, dly, cnt_low, slot_i;
      bit drv_d, rd_mode;
      hold = 0; dly = 0; cnt_low = 0; slot_i = 0; drv_d = 0; rd_mode = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            slave_low <= 1'b0;
            hold = 0; dly = 0; cnt_low = 0; slot_i = 0; drv_d = 0; rd_mode = 0;
         end else begin
            cyc++;
            if (cmd_valid && cmd_ready) begin
               acc_cnt++;
               slot_i = 0;
               rd_mode = (cmd == RD);
            end
            if (dly > 0) begin
               dly--;
               if (dly == 0) begin slave_low <= 1'b1; hold = 120 * CPU; end
            end else if (hold > 0) begin
               hold--;
               if (hold == 0) slave_low <= 1'b0;
            end
            if (ow_drive_low && !drv_d) begin
               cnt_low = 0;
               starts.push_back(cyc);
               if (rd_mode && slot_i < 8) begin
                  if (mask_bits[slot_i]) begin slave_low <= 1'b1; hold = 30 * CPU; end
                  slot_i++;
               end
            end
            if (ow_drive_low) cnt_low++;
            if (!ow_drive_low && drv_d) begin
               pulses.push_back(cnt_low);
               if (cnt_low >= T_RSTL * CPU && slave_on) dly = 30 * CPU;
            end
            drv_d = ow_drive_low;
         end
      end
   end

   task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input bit hold_valid,
                         output int lat, output logic [7:0] dout, output logic pres,
                         output int ready_hi, output logic busy_done);
      int guard;
      pulses.delete();
      starts.delete();
      @(negedge clk);
      cmd_valid = 1'b1; cmd = c; data_in = d;
      guard = 0;
      while (!cmd_ready && guard < 10) begin @(negedge clk); guard++; end
      @(posedge clk);
      @(negedge clk);
      if (!hold_valid) cmd_valid = 1'b0;
      cmd = ~c; data_in = ~d;
      lat = 1; ready_hi = 0;
      while (!done && lat < 20000) begin
         if (cmd_ready) ready_hi++;
         if (hold_valid) begin cmd = 2'($urandom); data_in = 8'($urandom); end
         @(negedge clk);
         lat++;
      end
      if (cmd_ready) ready_hi++;
      dout = data_out; pres = presence; busy_done = busy;
      cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_pulses(input string tag, input logic [1:0] c, input logic [7:0] d);
      int n, bad;
      n = (c == RS) ? 1 : ((c == PR) ? 0 : 8);
      check({tag, "_npulse"}, pulses.size(), n);
      for (int i = 0; i < n && i < pulses.size(); i++)
         check($sformatf("%s_low%0d", tag, i), pulses[i], model_low(c, d, i));
      if (n == 8 && starts.size() == 8) begin
         bad = 0;
         for (int i = 1; i < 8; i++)
            if (starts[i] - starts[i-1] != longint'(T_SLOT * CPU)) bad++;
         check({tag, "_slotlen"}, bad, 0);
      end
   endtask

   typedef struct {
      logic [1:0] c;
      logic [7:0] d;
      bit         slv;
      logic [7:0] mask;
      int         lat;
      logic [7:0] dout;
      logic       pres;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int lat, rdy, guard, a0;
      logic [7:0] dout, m_dout;
      logic pres, m_pres, bsy;
      logic [1:0] c;
      logic [7:0] d;

      tbl[0] = '{RS, 8'h00, 1'b1, 8'h00, 3841, 8'h00, 1'b1};
      tbl[1] = '{PR, 8'h00, 1'b1, 8'h00, 1,    8'h00, 1'b1};
      tbl[2] = '{RS, 8'h00, 1'b0, 8'h00, 3841, 8'h00, 1'b0};
      tbl[3] = '{PR, 8'h00, 1'b0, 8'h00, 1,    8'h00, 1'b0};
      tbl[4] = '{WR, 8'hA5, 1'b0, 8'h00, 2241, 8'h00, 1'b0};
      tbl[5] = '{RD, 8'h00, 1'b0, 8'hC3, 2241, 8'h3C, 1'b0};
      tbl[6] = '{WR, 8'h00, 1'b0, 8'h00, 2241, 8'h3C, 1'b0};
      tbl[7] = '{RD, 8'h5A, 1'b0, 8'h00, 2241, 8'hFF, 1'b0};
      tbl[8] = '{RD, 8'h00, 1'b0, 8'hFF, 2241, 8'h00, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_dout", int'(data_out), 0);
      check("rst_pres", int'(presence), 0);
      check("rst_drive", int'(ow_drive_low), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         slave_on = tbl[i].slv;
         mask_bits = tbl[i].mask;
         do_cmd(tbl[i].c, tbl[i].d, 1'b0, lat, dout, pres, rdy, bsy);
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].dout));
         check($sformatf("tbl%0d_pres", i), int'(pres), int'(tbl[i].pres));
         check($sformatf("tbl%0d_busy", i), int'(bsy), 1);
         check_pulses($sformatf("tbl%0d", i), tbl[i].c, tbl[i].d);
      end
      m_dout = tbl[8].dout;
      m_pres = tbl[8].pres;

      // cmd_valid held high with changing commands during a WRITE
      a0 = acc_cnt;
      do_cmd(WR, 8'h0F, 1'b1, lat, dout, pres, rdy, bsy);
      check("hold_lat", lat, model_lat(WR));
      check("hold_ready_hi", rdy, 0);
      check("hold_accepts", acc_cnt - a0, 1);
      check("hold_dout", int'(dout), int'(m_dout));
      check_pulses("hold", WR, 8'h0F);

      for (int k = 0; k < 6; k++) begin
         c = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         slave_on = 1'($urandom_range(0, 1));
         mask_bits = 8'($urandom);
         if (c == RD) m_dout = ~mask_bits;
         if (c == RS) m_pres = slave_on;
         do_cmd(c, d, 1'b0, lat, dout, pres, rdy, bsy);
         check($sformatf("rnd%0d_lat", k), lat, model_lat(c));
         check($sformatf("rnd%0d_dout", k), int'(dout), int'(m_dout));
         check($sformatf("rnd%0d_pres", k), int'(pres), int'(m_pres));
         check_pulses($sformatf("rnd%0d", k), c, d);
      end

      // Asynchronous reset while a write-0 slot is driving the bus low
      @(negedge clk);
      cmd_valid = 1'b1; cmd = WR; data_in = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      guard = 0;
      while (!(starts.size() >= 3 && ow_drive_low) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("rstmid_reach", int'(guard < 5000), 1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid_drive", int'(ow_drive_low), 0);
      check("rstmid_ready", int'(cmd_ready), 1);
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_done", int'(done), 0);
      check("rstmid_dout", int'(data_out), 0);
      check("rstmid_pres", int'(presence), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      slave_on = 1'b1;
      do_cmd(RS, 8'h00, 1'b0, lat, dout, pres, rdy, bsy);
      check("after_rst_lat", lat, model_lat(RS));
      check("after_rst_pres", int'(pres), 1);
      check("after_rst_dout", int'(dout), 0);
      check_pulses("after_rst", RS, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
